// File: rtl/serial_comp_n.sv
// Bit-serial MSB-first magnitude comparator with early exit on the first differing bit.
// Define CMP_SIGNED_EN to compare two's-complement operands instead of unsigned ones.
module serial_comp_n #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);
   // state | meaning
   // IDLE  | waiting for start, operands captured on the accepting edge
   // RUN   | one bit pair compared per cycle, MSB first
   // DONE  | result valid, done pulses for this single cycle

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_sh_a;
   logic [WIDTH-1:0] r_sh_b;
   logic [IW-1:0]    r_idx;

   logic [WIDTH-1:0] w_cap_a;
   logic [WIDTH-1:0] w_cap_b;
   logic             w_bit_a;
   logic             w_bit_b;

`ifdef CMP_SIGNED_EN
   // Flipping the sign bit maps two's complement onto offset binary, so the unsigned walk still works.
   assign w_cap_a = a ^ {1'b1, {(WIDTH-1){1'b0}}};
   assign w_cap_b = b ^ {1'b1, {(WIDTH-1){1'b0}}};
`else
   assign w_cap_a = a;
   assign w_cap_b = b;
`endif

   assign w_bit_a = r_sh_a[WIDTH-1];
   assign w_bit_b = r_sh_b[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_sh_a  <= '0;
         r_sh_b  <= '0;
         r_idx   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         gt      <= 1'b0;
         eq      <= 1'b0;
         lt      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sh_a  <= w_cap_a;
                  r_sh_b  <= w_cap_b;
                  r_idx   <= IDX_TOP;
                  busy    <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_bit_a != w_bit_b) begin
                  gt      <= w_bit_a;
                  lt      <= ~w_bit_a;
                  eq      <= 1'b0;
                  done    <= 1'b1;
                  r_state <= DONE;
               end else if (r_idx == '0) begin
                  gt      <= 1'b0;
                  eq      <= 1'b1;
                  lt      <= 1'b0;
                  done    <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_sh_a <= {r_sh_a[WIDTH-2:0], 1'b0};
                  r_sh_b <= {r_sh_b[WIDTH-2:0], 1'b0};
                  r_idx  <= r_idx - IW'(1);
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_comp_n.sv
// Self-checking bench for serial_comp_n: an 8-bit and a 4-bit instance checked against a scoreboard.
// Expected results follow CMP_SIGNED_EN, so the same bench covers both builds.
module tb_serial_comp_n;
   logic       clk = 1'b0;
   logic       rst;
   logic       start8, start4;
   logic [7:0] a8, b8;
   logic [3:0] a4, b4;
   logic       busy8, done8, gt8, eq8, lt8;
   logic       busy4, done4, gt4, eq4, lt4;

   typedef struct {
      logic gt;
      logic eq;
      logic lt;
      int   k;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   serial_comp_n #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8)
   );

   serial_comp_n #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .gt(gt4), .eq(eq4), .lt(lt4)
   );

   function automatic exp_t model(int w, logic [7:0] av, logic [7:0] bv);
      exp_t e;
      int   ia, ib;
      bit   found;
      ia = int'(av) & ((1 << w) - 1);
      ib = int'(bv) & ((1 << w) - 1);
`ifdef CMP_SIGNED_EN
      if (ia >= (1 << (w - 1))) ia = ia - (1 << w);
      if (ib >= (1 << (w - 1))) ib = ib - (1 << w);
`endif
      e.gt = (ia > ib);
      e.eq = (ia == ib);
      e.lt = (ia < ib);
      e.k  = w;
      found = 1'b0;
      for (int i = w - 1; i >= 0; i--) begin
         if (!found && av[i] != bv[i]) begin
            found = 1'b1;
            e.k   = w - i;
         end
      end
      return e;
   endfunction

   // Returns on the negedge after the capture edge.
   task automatic issue8(input logic [7:0] av, input logic [7:0] bv);
      @(negedge clk);
      a8 = av; b8 = bv; start8 = 1'b1;
      q8.push_back(model(8, av, bv));
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic issue4(input logic [3:0] av, input logic [3:0] bv);
      @(negedge clk);
      a4 = av; b4 = bv; start4 = 1'b1;
      q4.push_back(model(4, {4'h0, av}, {4'h0, bv}));
      @(negedge clk);
      start4 = 1'b0;
   endtask

   // Measured k is the number of RUN edges; a timeout yields an impossible k.
   task automatic wait_done8(output int kmeas, output int busycnt);
      int cyc;
      cyc = 1;
      busycnt = int'(busy8);
      while (!done8 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         busycnt += int'(busy8);
      end
      kmeas = cyc - 1;
   endtask

   task automatic wait_done4(output int kmeas);
      int cyc;
      cyc = 1;
      while (!done4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      kmeas = cyc - 1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({busy8, done8, gt8, eq8, lt8} !== 5'b0) begin
         bad++;
         $display("FAIL reset8 busy/done/gt/eq/lt=%b required 00000", {busy8, done8, gt8, eq8, lt8});
      end
      total++;
      if ({busy4, done4, gt4, eq4, lt4} !== 5'b0) begin
         bad++;
         $display("FAIL reset4 busy/done/gt/eq/lt=%b required 00000", {busy4, done4, gt4, eq4, lt4});
      end
      rst = 1'b0;
   endtask

   task automatic test_vectors();
      logic [7:0] va [8];
      logic [7:0] vb [8];
      exp_t e;
      int   km, bc;
      va = '{8'h80, 8'hFF, 8'h5A, 8'h03, 8'h00, 8'h7F, 8'h00, 8'h00};
      vb = '{8'h7F, 8'hFE, 8'h5A, 8'h02, 8'h00, 8'h80, 8'h00, 8'h00};
      for (int i = 6; i < 8; i++) begin
         va[i] = 8'($urandom);
         vb[i] = 8'($urandom);
      end
      for (int i = 0; i < 8; i++) begin
         issue8(va[i], vb[i]);
         wait_done8(km, bc);
         e = q8.pop_front();
         total++;
         if ({gt8, eq8, lt8} !== {e.gt, e.eq, e.lt} || km != e.k) begin
            bad++;
            $display("FAIL vec a=%h b=%h gt/eq/lt=%b%b%b k=%0d required %b%b%b k=%0d",
                     va[i], vb[i], gt8, eq8, lt8, km, e.gt, e.eq, e.lt, e.k);
         end
         total++;
         if (bc != e.k + 1) begin
            bad++;
            $display("FAIL busy_len a=%h b=%h busy cycles=%0d required %0d", va[i], vb[i], bc, e.k + 1);
         end
         @(negedge clk);
         total++;
         if ({busy8, done8} !== 2'b00) begin
            bad++;
            $display("FAIL done_pulse a=%h b=%h busy/done after=%b%b required 00", va[i], vb[i], busy8, done8);
         end
      end
   endtask

   task automatic test_hold();
      exp_t prev, e;
      int   km, bc;
      issue8(8'h03, 8'h02);
      wait_done8(km, bc);
      prev = q8.pop_front();
      issue8(8'h5A, 8'h5A);
      total++;
      if ({gt8, eq8, lt8, busy8} !== {prev.gt, prev.eq, prev.lt, 1'b1}) begin
         bad++;
         $display("FAIL hold_at_capture gt/eq/lt/busy=%b%b%b%b required %b%b%b1",
                  gt8, eq8, lt8, busy8, prev.gt, prev.eq, prev.lt);
      end
      wait_done8(km, bc);
      e = q8.pop_front();
      total++;
      if ({gt8, eq8, lt8} !== {e.gt, e.eq, e.lt} || km != e.k) begin
         bad++;
         $display("FAIL hold_eq gt/eq/lt=%b%b%b k=%0d required %b%b%b k=%0d",
                  gt8, eq8, lt8, km, e.gt, e.eq, e.lt, e.k);
      end
      @(negedge clk);
   endtask

   // start stays high; operands are scrambled whenever the DUT should be ignoring them.
   task automatic test_back_to_back();
      logic [7:0] va [4];
      logic [7:0] vb [4];
      exp_t e;
      int   cyc;
      va = '{8'h10, 8'hC3, 8'h7F, 8'h01};
      vb = '{8'h20, 8'hC3, 8'h80, 8'h00};
      @(negedge clk);
      a8 = va[0]; b8 = vb[0]; start8 = 1'b1;
      q8.push_back(model(8, va[0], vb[0]));
      cyc = 0;
      for (int n = 0; n < 4; n++) begin
         do begin
            @(negedge clk);
            cyc++;
            if (!done8) begin
               a8 = 8'($urandom);
               b8 = 8'($urandom);
            end
         end while (!done8 && cyc < 40);
         e = q8.pop_front();
         total++;
         if ({gt8, eq8, lt8} !== {e.gt, e.eq, e.lt} || cyc != e.k + ((n == 0) ? 1 : 2)) begin
            bad++;
            $display("FAIL b2b n=%0d gt/eq/lt=%b%b%b interval=%0d required %b%b%b interval=%0d",
                     n, gt8, eq8, lt8, cyc, e.gt, e.eq, e.lt, e.k + ((n == 0) ? 1 : 2));
         end
         if (n < 3) begin
            @(negedge clk);
            a8 = va[n+1]; b8 = vb[n+1];
            q8.push_back(model(8, va[n+1], vb[n+1]));
            cyc = 1;
         end
      end
      start8 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      exp_t e;
      int   km, bc;
      bit   saw_done;
      issue8(8'h80, 8'h7F);
      wait_done8(km, bc);
      e = q8.pop_front();
      total++;
      if ({gt8, eq8, lt8} !== {e.gt, e.eq, e.lt}) begin
         bad++;
         $display("FAIL pre_abort gt/eq/lt=%b%b%b required %b%b%b", gt8, eq8, lt8, e.gt, e.eq, e.lt);
      end
      issue8(8'h01, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(q8.pop_back());
      total++;
      if ({busy8, done8, gt8, eq8, lt8} !== 5'b0) begin
         bad++;
         $display("FAIL abort_clear busy/done/gt/eq/lt=%b required 00000", {busy8, done8, gt8, eq8, lt8});
      end
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done8) saw_done = 1'b1;
      end
      total++;
      if (saw_done !== 1'b0) begin
         bad++;
         $display("FAIL abort_no_done saw done=%b required 0", saw_done);
      end
      issue8(8'h01, 8'h00);
      wait_done8(km, bc);
      e = q8.pop_front();
      total++;
      if ({gt8, eq8, lt8} !== {e.gt, e.eq, e.lt} || km != e.k) begin
         bad++;
         $display("FAIL post_abort gt/eq/lt=%b%b%b k=%0d required %b%b%b k=%0d",
                  gt8, eq8, lt8, km, e.gt, e.eq, e.lt, e.k);
      end
      @(negedge clk);
   endtask

   task automatic test_exhaustive4();
      exp_t e;
      int   km;
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            issue4(4'(ai), 4'(bi));
            wait_done4(km);
            e = q4.pop_front();
            total++;
            if ({gt4, eq4, lt4} !== {e.gt, e.eq, e.lt} || km != e.k) begin
               bad++;
               $display("FAIL w4 a=%h b=%h gt/eq/lt=%b%b%b k=%0d required %b%b%b k=%0d",
                        ai, bi, gt4, eq4, lt4, km, e.gt, e.eq, e.lt, e.k);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      start8 = 1'b0; start4 = 1'b0;
      a8 = '0; b8 = '0; a4 = '0; b4 = '0;
      test_reset();
      test_vectors();
      test_hold();
      test_back_to_back();
      test_reset_abort();
      test_exhaustive4();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
